// File: rtl/exmem_pkg.sv
// rtl/exmem_pkg.sv - shared types and constants for the EX/MEM skid stage
package exmem_pkg;

  localparam int EXM_DATA_W = 32;
  localparam int EXM_REG_AW = 5;
  localparam int EXM_PC_W   = 32;

  // ALU control codes whose overflow is architecturally visible (signed add/sub)
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0010;

  // Occupancy of the two-register skid buffer
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  typedef struct packed {
    logic [EXM_DATA_W-1:0] result;
    logic                  zero;
    logic [EXM_REG_AW-1:0] rd;
    logic                  regwrite;
    logic                  memwrite;
    logic                  memtoreg;
    logic [EXM_DATA_W-1:0] store_data;
    logic [EXM_PC_W-1:0]   pc;
    logic                  exc;
  } entry_t;

  // Decode helper: signed add/sub trap on overflow, everything else does not
  function automatic logic alu_traps_ovf(input logic [3:0] alu_ctrl);
    return (alu_ctrl == ALU_ADD) || (alu_ctrl == ALU_SUB);
  endfunction

endpackage

// File: rtl/exmem_entry_pack.sv
// rtl/exmem_entry_pack.sv - packs ALU outputs into an entry, converting trapping overflow to an exception
module exmem_entry_pack
  import exmem_pkg::*;
(
  input  logic [EXM_DATA_W-1:0] in_result,
  input  logic                  in_zero,
  input  logic                  in_overflow,
  input  logic                  in_trap_ovf,
  input  logic [EXM_REG_AW-1:0] in_rd,
  input  logic                  in_regwrite,
  input  logic                  in_memwrite,
  input  logic                  in_memtoreg,
  input  logic [EXM_DATA_W-1:0] in_store_data,
  input  logic [EXM_PC_W-1:0]   in_pc,
  output entry_t                entry
);

  // A trapping overflow keeps result/pc for EPC but must not write any architectural state
  always_comb begin
    entry            = '0;
    entry.result     = in_result;
    entry.zero       = in_zero;
    entry.rd         = in_rd;
    entry.regwrite   = in_regwrite;
    entry.memwrite   = in_memwrite;
    entry.memtoreg   = in_memtoreg;
    entry.store_data = in_store_data;
    entry.pc         = in_pc;
    entry.exc        = 1'b0;
    if (in_overflow && in_trap_ovf) begin
      entry.regwrite = 1'b0;
      entry.memwrite = 1'b0;
      entry.memtoreg = 1'b0;
      entry.exc      = 1'b1;
    end
  end

endmodule

// File: rtl/ex_mem_skid.sv
// rtl/ex_mem_skid.sv - EX/MEM 2-entry skid buffer with overflow exception lock (optional FWD_EN forwarding port)
module ex_mem_skid
  import exmem_pkg::*;
#(
  parameter int DATA_W = EXM_DATA_W,
  parameter int REG_AW = EXM_REG_AW,
  parameter int PC_W   = EXM_PC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_zero,
  input  logic              in_overflow,
  input  logic              in_trap_ovf,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_regwrite,
  input  logic              in_memwrite,
  input  logic              in_memtoreg,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_zero,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_regwrite,
  output logic              out_memwrite,
  output logic              out_memtoreg,
  output logic [DATA_W-1:0] out_store_data,
  output logic [PC_W-1:0]   out_pc,
`ifdef FWD_EN
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
`endif
  output logic              out_exc
);

  entry_t in_entry, main_q, skid_q;
  state_e state_q, state_n;
  logic   exc_lock_q, exc_lock_n;
  logic   in_ready_q;
  logic   enq, deq;
  logic   load_main_in, load_main_skid, load_skid_in;

  exmem_entry_pack u_pack (
    .in_result     (in_result),
    .in_zero       (in_zero),
    .in_overflow   (in_overflow),
    .in_trap_ovf   (in_trap_ovf),
    .in_rd         (in_rd),
    .in_regwrite   (in_regwrite),
    .in_memwrite   (in_memwrite),
    .in_memtoreg   (in_memtoreg),
    .in_store_data (in_store_data),
    .in_pc         (in_pc),
    .entry         (in_entry)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign enq       = in_valid && in_ready_q;
  assign deq       = out_valid && out_ready;

  // Next occupancy, which register loads from where, and the exception lock
  always_comb begin
    state_n        = state_q;
    exc_lock_n     = exc_lock_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    if (flush) begin
      state_n    = ST_EMPTY;
      exc_lock_n = 1'b0;
    end else begin
      if (enq && in_entry.exc) exc_lock_n = 1'b1;
      case (state_q)
        ST_EMPTY: begin
          if (enq) begin
            state_n      = ST_ONE;
            load_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (enq && deq) begin
            load_main_in = 1'b1;
          end else if (enq) begin
            state_n      = ST_TWO;
            load_skid_in = 1'b1;
          end else if (deq) begin
            state_n = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only a dequeue can happen
          if (deq) begin
            state_n        = ST_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_n = ST_EMPTY;
      endcase
    end
  end

  // Occupancy, lock and a registered in_ready so out_ready never reaches the ALU combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      exc_lock_q <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_n;
      exc_lock_q <= exc_lock_n;
      in_ready_q <= (state_n != ST_TWO) && !exc_lock_n;
    end
  end

  // Entry storage; flush leaves the data alone and only drops the valid state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)        main_q <= in_entry;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid_in)        skid_q <= in_entry;
    end
  end

  assign out_result     = main_q.result;
  assign out_zero       = main_q.zero;
  assign out_rd         = main_q.rd;
  assign out_regwrite   = main_q.regwrite;
  assign out_memwrite   = main_q.memwrite;
  assign out_memtoreg   = main_q.memtoreg;
  assign out_store_data = main_q.store_data;
  assign out_pc         = main_q.pc;
  assign out_exc        = main_q.exc;

`ifdef FWD_EN
  assign fwd_valid = out_valid && main_q.regwrite && !main_q.memtoreg && (main_q.rd != '0);
  assign fwd_rd    = main_q.rd;
  assign fwd_data  = main_q.result;
`endif

endmodule

// File: doc/ex_mem_skid.md
Name: ex_mem_skid

Overview:
- EX/MEM boundary stage directly downstream of the execute-stage ALU.
- Captures the ALU result, zero and overflow flags together with the instruction's control and destination fields.
- Buffers them in a 2-entry skid buffer with valid/ready handshakes on both sides, so memory-stage stalls never combinationally reach the ALU.
- Converts a signed-arithmetic overflow into a precise exception record, and blocks further issue until the front end flushes.

Parameters:
- DATA_W, 32, width of ALU result and store data
- REG_AW, 5, register-file address width
- PC_W, 32, program-counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream (ALU stage) entry valid
- in_ready  out  1  stage can accept an entry this cycle
- in_result  in  DATA_W  ALU result
- in_zero  in  1  ALU zero flag
- in_overflow  in  1  ALU overflow flag
- in_trap_ovf  in  1  instruction traps on overflow (signed add/sub)
- in_rd  in  REG_AW  destination register
- in_regwrite  in  1  writes register file
- in_memwrite  in  1  store
- in_memtoreg  in  1  load
- in_store_data  in  DATA_W  store data
- in_pc  in  PC_W  instruction PC
- flush  in  1  synchronous flush of all entries and the exception lock
- out_valid  out  1  entry presented to MEM stage
- out_ready  in  1  MEM stage accepts
- out_result, out_zero, out_rd, out_regwrite, out_memwrite, out_memtoreg, out_store_data, out_pc  out  as inputs  head-entry fields
- out_exc  out  1  head entry is an overflow exception

Behaviour:
- Handshake
  - Enqueue when in_valid && in_ready.
  - Dequeue when out_valid && out_ready.
  - in_ready is a registered signal: in_ready = !skid_valid && !exc_lock. It never depends combinationally on out_ready.
- Storage
  - Two registers: main (feeds the out_* ports) and skid.
  - State follows the valid bits: EMPTY (neither valid), ONE (main only), TWO (main and skid).
- Transitions
  - EMPTY + enq → ONE; the entry loads into main.
  - ONE + enq + deq → ONE; the new entry loads into main.
  - ONE + enq, no deq → TWO; the entry loads into skid.
  - ONE + deq, no enq → EMPTY.
  - TWO + deq → ONE; skid moves to main. No enqueue is possible in TWO because in_ready is 0.
- Latency: 1 cycle from enqueue to out_valid when the stage is empty. Sustained throughput is 1 entry per cycle while out_ready is held high.
- Overflow conversion at enqueue, when in_overflow && in_trap_ovf:
  - Stored regwrite, memwrite and memtoreg are forced to 0 and exc is set to 1.
  - result and pc are kept for EPC/diagnostics.
  - exc_lock is set on the following edge, dropping in_ready.
  - exc_lock stays set until flush. Dequeuing the exception entry does not clear it.
- Overflow without in_trap_ovf (unsigned ops): the flags are stored unchanged and exc is 0.
- Flush: synchronous, with priority over enqueue and dequeue in the same cycle. Clears both valid bits and exc_lock. Data registers are left unchanged.
- Reset (asynchronous, rst_n=0): main/skid valid = 0, exc_lock = 0.
  - Observable outputs: out_valid=0, out_exc=0, in_ready=0 while rst_n is low, then in_ready=1 on the first edge after release.
  - All data outputs reset to 0.
  - A reset asserted mid-transfer drops every buffered entry.
- Outputs of the out_* fields are meaningful only while out_valid=1. The block holds them stable while out_valid && !out_ready.

Optional Feature:
- FWD_EN
  - When defined, adds ports fwd_valid (out 1), fwd_rd (out REG_AW) and fwd_data (out DATA_W).
  - These present the main entry for EX-stage operand forwarding: fwd_valid = out_valid && out_regwrite && !out_memtoreg && out_rd != 0.
- When FWD_EN is undefined, the ports and logic are absent.

Decomposition:
- Shared package exmem_pkg holds:
  - the entry struct typedef (result, zero, rd, regwrite, memwrite, memtoreg, store_data, pc, exc);
  - the state encoding constants ST_EMPTY, ST_ONE, ST_TWO;
  - the ALU control code constants (signed add 4'b0000, signed sub 4'b0010), used by decode to derive in_trap_ovf.
- One sub-module, exmem_entry_pack: a combinational pack/convert of the inputs into the entry struct, including the overflow conversion.

Test Plan:
- Reset release, then a single enqueue: in_result=32'h0000_0005, rd=3, regwrite=1 → next cycle out_valid=1, out_result=5, out_rd=3, out_exc=0.
- out_ready held 0, three back-to-back enqueues A,B,C → A and B accepted, in_ready=0 before C. Then out_ready=1 → outputs A, B, C in order with no loss or duplication.
- Overflow trap: in_result=32'h8000_0000, in_overflow=1, in_trap_ovf=1, regwrite=1 → out_exc=1, out_regwrite=0, in_ready=0 on following cycles. in_ready stays 0 after dequeue until flush, then 1.
- Unsigned overflow: in_overflow=1, in_trap_ovf=0, regwrite=1 → out_exc=0, out_regwrite=1, in_ready stays 1.
- flush asserted in the same cycle as an enqueue with two entries buffered → next cycle out_valid=0 and in_ready=1; the flushed-cycle entry never appears.
- rst_n pulsed low asynchronously mid-cycle while in TWO → out_valid=0 immediately, no entry emerges after release.
